// File: rtl/i_memory_if.sv
// EX/MEM -> MEM stage bus: pipeline inputs from execute plus the MEM/WB and branch outputs.
interface i_memory_if;
  logic [4:0]  ctr_bits;
  logic [31:0] add_result;
  logic        zero;
  logic [31:0] alu_result;
  logic [31:0] rdata2;
  logic [4:0]  five_bit_muxin;

  logic        pcsrc;
  logic [31:0] branch_target;
  logic [1:0]  wb_ctl;
  logic [31:0] mem_rdata;
  logic [31:0] alu_result_out;
  logic [4:0]  five_bit_muxout;
  logic        mem_fault;
  logic        fault_sticky;

  modport master (
    output ctr_bits, add_result, zero, alu_result, rdata2, five_bit_muxin,
    input  pcsrc, branch_target, wb_ctl, mem_rdata, alu_result_out,
           five_bit_muxout, mem_fault, fault_sticky
  );

  modport slave (
    input  ctr_bits, add_result, zero, alu_result, rdata2, five_bit_muxin,
    output pcsrc, branch_target, wb_ctl, mem_rdata, alu_result_out,
           five_bit_muxout, mem_fault, fault_sticky
  );
endinterface

// File: rtl/i_memory.sv
// MIPS MEM stage: data memory, branch resolution and the MEM/WB pipeline register.
// Flags misaligned or out-of-range accesses; faulting stores are dropped.
module i_memory #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input logic       clock,
  input logic       reset,
  i_memory_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTL_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned HI_LSB = ADDR_W + 2;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              regwrite, memtoreg, branch, memread, memwrite;
  logic              access, fault, wr_ok, rd_ok;
  logic [ADDR_W-1:0] index;

  logic [1:0]        wb_ctl_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [REG_W-1:0]  dest_q;
  logic              mem_fault_q;
  logic              fault_sticky_q;

  logic [CTL_W-1:0]  ctl;

  assign ctl      = bus.ctr_bits;
  assign regwrite = ctl[4];
  assign memtoreg = ctl[3];
  assign branch   = ctl[2];
  assign memread  = ctl[1];
  assign memwrite = ctl[0];

  // Any access must be word aligned and inside the DEPTH*4 byte window.
  assign access = memread | memwrite;
  assign index  = bus.alu_result[ADDR_W+1:2];
  assign fault  = access & ((bus.alu_result[1:0] != 2'b00) ||
                            (bus.alu_result[DATA_W-1:HI_LSB] != '0));
  assign wr_ok  = memwrite & ~fault;
  assign rd_ok  = memread & ~fault;

  assign bus.pcsrc         = branch & bus.zero;
  assign bus.branch_target = bus.add_result;

  // Reset clears every word and discards a store presented in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[index] <= bus.rdata2;
    end
  end

  // MEM/WB register; the read sees pre-edge memory contents.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_ctl_q       <= '0;
      mem_rdata_q    <= '0;
      alu_result_q   <= '0;
      dest_q         <= '0;
      mem_fault_q    <= 1'b0;
      fault_sticky_q <= 1'b0;
    end else begin
      wb_ctl_q       <= {regwrite, memtoreg};
      mem_rdata_q    <= rd_ok ? mem[index] : '0;
      alu_result_q   <= bus.alu_result;
      dest_q         <= bus.five_bit_muxin;
      mem_fault_q    <= fault;
      fault_sticky_q <= fault_sticky_q | fault;
    end
  end

  assign bus.wb_ctl          = wb_ctl_q;
  assign bus.mem_rdata       = mem_rdata_q;
  assign bus.alu_result_out  = alu_result_q;
  assign bus.five_bit_muxout = dest_q;
  assign bus.mem_fault       = mem_fault_q;
  assign bus.fault_sticky    = fault_sticky_q;

endmodule
